// File: rtl/sram_responder.sv
// ---------------------------------------------------------------------------
// sram_responder
//
// Pin-side emulation of a 16-bit asynchronous SRAM, answering the existing
// SRAM controller from on-chip RAM. The active-low strobes are sampled on
// every rising clk edge. Writes go straight into the RAM. Reads return
// through a READ_LAT-deep pipeline whose final valid bit drives the pad
// output-enable. Protocol violations are recorded in sticky status bits.
//
// Parameters:
//   ADDR_W    implemented word-address bits, depth = 2**ADDR_W (8..18)
//   READ_LAT  clocks from read sample to data_pins_out/data_oe valid (1..3)
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-low reset
//   address_pins   18-bit word address from the controller
//   data_pins_in   write data from the controller
//   data_pins_out  read data toward the controller (holds its last value)
//   data_oe        high while data_pins_out carries a valid read word
//   CS, WE, OE     active-low chip select / write enable / output enable
//   clear_status   synchronous pulse that clears the sticky flags
//   contention     sticky: WE and OE low together while CS low
//   range_err      sticky: access with address_pins[17:ADDR_W] nonzero
//   read_count     (SRAM_RESPONDER_COUNT_EN) saturating accepted-read count
//   write_count    (SRAM_RESPONDER_COUNT_EN) saturating committed-write count
//
// Optional feature macro: SRAM_RESPONDER_COUNT_EN
// ---------------------------------------------------------------------------
module sram_responder #(
  parameter int ADDR_W   = 12,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [17:0] address_pins,
  input  logic [15:0] data_pins_in,
  output logic [15:0] data_pins_out,
  output logic        data_oe,
  input  logic        CS,
  input  logic        WE,
  input  logic        OE,
  input  logic        clear_status,
  output logic        contention,
  output logic        range_err
`ifdef SRAM_RESPONDER_COUNT_EN
  ,
  output logic [15:0] read_count,
  output logic [15:0] write_count
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  // Access decode
  logic              w_oor;
  logic              w_wr;
  logic              w_rd;
  logic              w_wr_commit;
  logic              w_cont_evt;
  logic              w_range_evt;
  logic [ADDR_W-1:0] w_idx;

  assign w_idx       = address_pins[ADDR_W-1:0];
  assign w_wr        = ~CS & ~WE;
  // A read needs WE high, so strobe contention never issues a read.
  assign w_rd        = ~CS & WE & ~OE;
  assign w_wr_commit = w_wr & ~w_oor;
  assign w_cont_evt  = ~CS & ~WE & ~OE;
  assign w_range_evt = (w_wr | w_rd) & w_oor;

  generate
    if (ADDR_W < 18) begin : g_range_chk
      assign w_oor = |address_pins[17:ADDR_W];
    end else begin : g_full_range
      assign w_oor = 1'b0;
    end
  endgenerate

  // Storage. Kept free of reset so it maps onto block RAM; the read port is
  // clock-enabled by w_rd so its register doubles as the first pipeline
  // stage and naturally holds its value between reads.
  logic [15:0] r_mem [0:DEPTH-1];
  logic [15:0] r_ram_q;
  logic        r_ram_oor;

  always_ff @(posedge clk) begin
    if (w_wr_commit) begin
      r_mem[w_idx] <= data_pins_in;
    end
  end

  // A write and a read can never be sampled on the same edge, so a read one
  // edge after a write always sees the stored word; no bypass is needed.
  always_ff @(posedge clk) begin
    if (w_rd) begin
      r_ram_q   <= r_mem[w_idx];
      r_ram_oor <= w_oor;
    end
  end

  // Read pipeline: stage 0 is the RAM output register, stages 1..READ_LAT-1
  // are plain registers that only load when the stage ahead is valid.
  logic [15:0]         w_sdata [READ_LAT];
  logic [READ_LAT-1:0] w_svld;
  logic                r_vld0;
  logic                w_into_final;
  logic                r_out_live;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld0 <= 1'b0;
    end else begin
      r_vld0 <= w_rd;
    end
  end

  assign w_sdata[0] = r_ram_oor ? 16'h0000 : r_ram_q;
  assign w_svld[0]  = r_vld0;

  genvar gi;
  generate
    for (gi = 1; gi < READ_LAT; gi++) begin : g_stage
      logic [15:0] r_data;
      logic        r_vld;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_data <= 16'h0000;
          r_vld  <= 1'b0;
        end else begin
          r_vld <= w_svld[gi-1];
          if (w_svld[gi-1]) begin
            r_data <= w_sdata[gi-1];
          end
        end
      end

      assign w_sdata[gi] = r_data;
      assign w_svld[gi]  = r_vld;
    end

    if (READ_LAT == 1) begin : g_final_lat1
      assign w_into_final = w_rd;
    end else begin : g_final_deep
      assign w_into_final = w_svld[READ_LAT-2];
    end
  endgenerate

  // The RAM output register has no reset, so the pins are forced to zero
  // until the first word reaches the final stage after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_live <= 1'b0;
    end else begin
      r_out_live <= r_out_live | w_into_final;
    end
  end

  assign data_pins_out = r_out_live ? w_sdata[READ_LAT-1] : 16'h0000;
  assign data_oe       = w_svld[READ_LAT-1];

  // Sticky status: a set event outranks clear_status on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      contention <= 1'b0;
      range_err  <= 1'b0;
    end else begin
      if (w_cont_evt) begin
        contention <= 1'b1;
      end else if (clear_status) begin
        contention <= 1'b0;
      end
      if (w_range_evt) begin
        range_err <= 1'b1;
      end else if (clear_status) begin
        range_err <= 1'b0;
      end
    end
  end

`ifdef SRAM_RESPONDER_COUNT_EN
  // Saturating activity counters; an increment coinciding with clear_status
  // leaves the counter at 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_count  <= 16'h0000;
      write_count <= 16'h0000;
    end else begin
      if (clear_status) begin
        read_count <= w_rd ? 16'h0001 : 16'h0000;
      end else if (w_rd && (read_count != 16'hFFFF)) begin
        read_count <= read_count + 16'h0001;
      end
      if (clear_status) begin
        write_count <= w_wr_commit ? 16'h0001 : 16'h0000;
      end else if (w_wr_commit && (write_count != 16'hFFFF)) begin
        write_count <= write_count + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_sram_responder
//
// Three responders (READ_LAT = 1, 2, 3, ADDR_W = 12) share one set of
// controller-side stimulus; each scenario task checks the instance whose
// latency it exercises. Inputs change 1 ns after the rising edge and
// outputs are observed at that same point, well away from the next edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sram_responder;

  logic        clk;
  logic        reset;
  logic [17:0] address_pins;
  logic [15:0] data_pins_in;
  logic        CS, WE, OE, clear_status;

  logic [15:0] dout1, dout2, dout3;
  logic        oe1, oe2, oe3;
  logic        cont1, cont2, cont3;
  logic        rerr1, rerr2, rerr3;

  int checks   = 0;
  int failures = 0;

  sram_responder #(.ADDR_W(12), .READ_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .address_pins(address_pins),
    .data_pins_in(data_pins_in), .data_pins_out(dout1), .data_oe(oe1),
    .CS(CS), .WE(WE), .OE(OE), .clear_status(clear_status),
    .contention(cont1), .range_err(rerr1)
  );

  sram_responder #(.ADDR_W(12), .READ_LAT(2)) u_lat2 (
    .clk(clk), .reset(reset), .address_pins(address_pins),
    .data_pins_in(data_pins_in), .data_pins_out(dout2), .data_oe(oe2),
    .CS(CS), .WE(WE), .OE(OE), .clear_status(clear_status),
    .contention(cont2), .range_err(rerr2)
  );

  sram_responder #(.ADDR_W(12), .READ_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset), .address_pins(address_pins),
    .data_pins_in(data_pins_in), .data_pins_out(dout3), .data_oe(oe3),
    .CS(CS), .WE(WE), .OE(OE), .clear_status(clear_status),
    .contention(cont3), .range_err(rerr3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One bus cycle: drive, let one rising edge sample it, settle 1 ns.
  task automatic cyc(input logic cs, input logic we, input logic oe,
                     input logic [17:0] addr, input logic [15:0] data,
                     input logic clr);
    CS = cs; WE = we; OE = oe; address_pins = addr;
    data_pins_in = data; clear_status = clr;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b1, 18'h0, 16'h0, 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    idle(3);
    reset = 1'b1;
    idle(10);
    checks++; if (oe1 !== 1'b0 || oe2 !== 1'b0 || oe3 !== 1'b0) begin failures++;
      $display("FAIL reset_oe got %b%b%b want 000", oe1, oe2, oe3); end
    checks++; if (dout1 !== 16'h0 || dout2 !== 16'h0 || dout3 !== 16'h0) begin failures++;
      $display("FAIL reset_dout got %h/%h/%h want 0000", dout1, dout2, dout3); end
    checks++; if (cont1 !== 1'b0 || rerr1 !== 1'b0) begin failures++;
      $display("FAIL reset_flags got cont=%b rerr=%b want 0/0", cont1, rerr1); end
    $display("txn reset+idle10 oe=%b dout=%h cont=%b rerr=%b", oe1, dout1, cont1, rerr1);
  endtask

  task automatic test_read_after_write;
    cyc(1'b0, 1'b0, 1'b1, 18'h00012, 16'hA55A, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 18'h00012, 16'h0000, 1'b0);
    $display("txn raw read 0x12 oe=%b dout=%h", oe1, dout1);
    checks++; if (oe1 !== 1'b1 || dout1 !== 16'hA55A) begin failures++;
      $display("FAIL raw_read got oe=%b data=%h want 1/a55a", oe1, dout1); end
    idle(1);
    checks++; if (oe1 !== 1'b0 || dout1 !== 16'hA55A) begin failures++;
      $display("FAIL raw_hold got oe=%b data=%h want 0/a55a", oe1, dout1); end
    // WE held low across two edges: the later data must win.
    cyc(1'b0, 1'b0, 1'b1, 18'h00007, 16'h0001, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 18'h00007, 16'h0002, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 18'h00007, 16'h0000, 1'b0);
    $display("txn held-WE read 0x7 oe=%b dout=%h", oe1, dout1);
    checks++; if (oe1 !== 1'b1 || dout1 !== 16'h0002) begin failures++;
      $display("FAIL held_we got oe=%b data=%h want 1/0002", oe1, dout1); end
    idle(1);
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_d [3];
    logic        exp_oe [3];
    exp_d[0] = 16'h1111; exp_d[1] = 16'h2222; exp_d[2] = 16'h3333;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 18'(i), exp_d[i], 1'b0);
    idle(1);
    // Stage-3 output during the three read edges: nothing yet, then word 0.
    exp_oe[0] = 1'b0; exp_oe[1] = 1'b0; exp_oe[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 18'(i), 16'h0, 1'b0);
      $display("txn lat3 read %0d oe3=%b dout3=%h oe1=%b dout1=%h", i, oe3, dout3, oe1, dout1);
      checks++; if (oe3 !== exp_oe[i]) begin failures++;
        $display("FAIL lat3_oe_early%0d got %b want %b", i, oe3, exp_oe[i]); end
      checks++; if (oe1 !== 1'b1 || dout1 !== exp_d[i]) begin failures++;
        $display("FAIL lat1_b2b%0d got oe=%b data=%h want 1/%h", i, oe1, dout1, exp_d[i]); end
    end
    checks++; if (dout3 !== 16'h1111) begin failures++;
      $display("FAIL lat3_word0 got %h want 1111", dout3); end
    for (int i = 1; i < 3; i++) begin
      idle(1);
      $display("txn lat3 drain %0d oe3=%b dout3=%h", i, oe3, dout3);
      checks++; if (oe3 !== 1'b1 || dout3 !== exp_d[i]) begin failures++;
        $display("FAIL lat3_word%0d got oe=%b data=%h want 1/%h", i, oe3, dout3, exp_d[i]); end
    end
    idle(1);
    checks++; if (oe3 !== 1'b0 || dout3 !== 16'h3333) begin failures++;
      $display("FAIL lat3_end got oe=%b data=%h want 0/3333", oe3, dout3); end
  endtask

  task automatic test_contention;
    cyc(1'b0, 1'b0, 1'b0, 18'h00005, 16'hBEEF, 1'b0);
    $display("txn contention write 0x5 cont=%b oe1=%b", cont1, oe1);
    checks++; if (cont1 !== 1'b1 || oe1 !== 1'b0) begin failures++;
      $display("FAIL cont_set got cont=%b oe=%b want 1/0", cont1, oe1); end
    idle(2);
    checks++; if (cont1 !== 1'b1 || oe2 !== 1'b0 || oe3 !== 1'b0) begin failures++;
      $display("FAIL cont_sticky got cont=%b oe2=%b oe3=%b want 1/0/0", cont1, oe2, oe3); end
    cyc(1'b0, 1'b1, 1'b0, 18'h00005, 16'h0000, 1'b0);
    checks++; if (oe1 !== 1'b1 || dout1 !== 16'hBEEF) begin failures++;
      $display("FAIL cont_readback got oe=%b data=%h want 1/beef", oe1, dout1); end
    cyc(1'b1, 1'b1, 1'b1, 18'h0, 16'h0, 1'b1);
    $display("txn clear_status cont=%b", cont1);
    checks++; if (cont1 !== 1'b0) begin failures++;
      $display("FAIL cont_clear got %b want 0", cont1); end
  endtask

  task automatic test_range;
    checks++; if (rerr1 !== 1'b0) begin failures++;
      $display("FAIL range_pre got %b want 0", rerr1); end
    cyc(1'b0, 1'b0, 1'b1, 18'h00000, 16'h0001, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 18'h01000, 16'hFFFF, 1'b0);
    checks++; if (rerr1 !== 1'b1) begin failures++;
      $display("FAIL range_wr_flag got %b want 1", rerr1); end
    cyc(1'b0, 1'b1, 1'b0, 18'h00000, 16'h0000, 1'b0);
    $display("txn read 0x0 after oor write oe=%b dout=%h", oe1, dout1);
    checks++; if (oe1 !== 1'b1 || dout1 !== 16'h0001) begin failures++;
      $display("FAIL range_alias got oe=%b data=%h want 1/0001", oe1, dout1); end
    cyc(1'b0, 1'b1, 1'b0, 18'h01000, 16'h0000, 1'b0);
    $display("txn oor read oe=%b dout=%h rerr=%b", oe1, dout1, rerr1);
    checks++; if (oe1 !== 1'b1 || dout1 !== 16'h0000) begin failures++;
      $display("FAIL range_rd got oe=%b data=%h want 1/0000", oe1, dout1); end
    // Set event on the same edge as clear_status: set wins.
    cyc(1'b0, 1'b1, 1'b0, 18'h01000, 16'h0000, 1'b1);
    checks++; if (rerr1 !== 1'b1) begin failures++;
      $display("FAIL range_set_prio got %b want 1", rerr1); end
    cyc(1'b1, 1'b1, 1'b1, 18'h0, 16'h0, 1'b1);
    checks++; if (rerr1 !== 1'b0) begin failures++;
      $display("FAIL range_clear got %b want 0", rerr1); end
    // CS high masks everything, even contention and out-of-range strobes.
    cyc(1'b1, 1'b0, 1'b0, 18'h01000, 16'h1234, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 18'h00000, 16'h5555, 1'b0);
    checks++; if (rerr1 !== 1'b0 || cont1 !== 1'b0 || oe1 !== 1'b0) begin failures++;
      $display("FAIL cs_mask_flags got rerr=%b cont=%b oe=%b want 0/0/0", rerr1, cont1, oe1); end
    cyc(1'b0, 1'b1, 1'b0, 18'h00000, 16'h0000, 1'b0);
    $display("txn read 0x0 after masked write dout=%h", dout1);
    checks++; if (oe1 !== 1'b1 || dout1 !== 16'h0001) begin failures++;
      $display("FAIL cs_mask_write got oe=%b data=%h want 1/0001", oe1, dout1); end
    idle(1);
  endtask

  task automatic test_reset_midread;
    // Word already on the pins when reset hits: must vanish at once.
    cyc(1'b0, 1'b1, 1'b0, 18'h00001, 16'h0000, 1'b0);
    idle(1);
    checks++; if (oe2 !== 1'b1 || dout2 !== 16'h2222) begin failures++;
      $display("FAIL lat2_read got oe=%b data=%h want 1/2222", oe2, dout2); end
    #2 reset = 1'b0;
    #1;
    $display("txn async reset with word out oe2=%b dout2=%h", oe2, dout2);
    checks++; if (oe2 !== 1'b0 || dout2 !== 16'h0000) begin failures++;
      $display("FAIL rst_async got oe=%b data=%h want 0/0000", oe2, dout2); end
    @(posedge clk); #1;
    reset = 1'b1;
    // Read in flight when reset hits one clock later.
    cyc(1'b0, 1'b1, 1'b0, 18'h00002, 16'h0000, 1'b0);
    reset = 1'b0;
    CS = 1'b1; WE = 1'b1; OE = 1'b1;
    #1;
    checks++; if (oe2 !== 1'b0) begin failures++;
      $display("FAIL rst_inflight_now got oe=%b want 0", oe2); end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      $display("txn post-reset idle %0d oe2=%b dout2=%h", i, oe2, dout2);
      checks++; if (oe2 !== 1'b0 || dout2 !== 16'h0000 || oe3 !== 1'b0) begin failures++;
        $display("FAIL rst_no_stale%0d got oe2=%b data=%h oe3=%b want 0/0000/0", i, oe2, dout2, oe3); end
    end
  endtask

  initial begin
    reset = 1'b0; CS = 1'b1; WE = 1'b1; OE = 1'b1;
    address_pins = 18'h0; data_pins_in = 16'h0; clear_status = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_read_after_write();
    test_back_to_back();
    test_contention();
    test_range();
    test_reset_midread();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Synthesizable emulation of the external 16-bit asynchronous SRAM device: the pin-side responder to the existing SRAM controller.
- Lets the NES core run on boards or benches without a physical SRAM.
- Samples the active-low CS/WE/OE strobes each clock, stores words in on-chip RAM, and returns read data through a fixed-latency pipeline with a matching output-enable.
- Flags protocol violations (strobe contention, out-of-range address) in sticky status bits.

Parameters:
ADDR_W, 12, implemented word-address bits (depth = 2**ADDR_W words of 16 bits); legal range 8..18
READ_LAT, 1, clocks from read sample to data_pins_out/data_oe valid; legal 1..3

Ports:
clk  input  1  system clock (12 MHz nominal)
reset  input  1  asynchronous, active-low reset
address_pins  input  18  word address from controller
data_pins_in  input  16  write data from controller
data_pins_out  output  16  read data toward controller
data_oe  output  1  high when data_pins_out is driven/valid (pad tristate enable)
CS  input  1  chip select, low active
WE  input  1  write enable, low active
OE  input  1  output enable, low active
clear_status  input  1  synchronous pulse, clears sticky flags
contention  output  1  sticky: WE and OE sampled low together while CS low
range_err  output  1  sticky: access with address_pins[17:ADDR_W] nonzero

Behaviour:
- Reset (reset=0, asynchronous): data_pins_out=16'h0000, data_oe=0, contention=0, range_err=0, read pipeline valid bits cleared. RAM contents are not reset and are undefined until written.
- Access decode on every rising clk edge:
  - idle: CS=1, or CS=0 with WE=1 and OE=1.
  - write: CS=0, WE=0.
  - read: CS=0, WE=1, OE=0.
- Write: mem[address_pins[ADDR_W-1:0]] <= data_pins_in at the sampling edge. A write is repeated on every edge WE stays low; the last sampled data wins.
- Read: the word is looked up at the sampling edge and passed through READ_LAT register stages. Each stage carries data and a valid bit.
  - data_oe = valid bit of the final stage.
  - data_pins_out = data of the final stage when valid; otherwise it holds its last value.
  - Back-to-back reads on consecutive edges produce back-to-back outputs; throughput is one word per clock.
- Read-after-write: a read sampled on the edge after a write to the same address returns the new data. Implementation uses either a write-first RAM or a bypass register.
- Same-edge WE=0 and OE=0 with CS=0:
  - treated as a write (write has priority);
  - no read is issued, so the valid bit entering the pipeline is 0;
  - contention is set.
- Out of range (any of address_pins[17:ADDR_W] set, checked only when ADDR_W<18):
  - write is suppressed;
  - read is issued with data 16'h0000 and valid=1;
  - range_err is set.
  - Idle cycles never flag.
- Sticky flags:
  - a set event has priority over clear_status on the same edge;
  - otherwise clear_status=1 clears both flags at the edge.
- CS=1 masks WE/OE completely: no write, no read, no flags.
- Reset mid-read: in-flight pipeline contents are discarded and data_oe drops immediately (asynchronously). A write sampled on the same edge reset asserts is not guaranteed.

Optional Feature:
- Macro: SRAM_RESPONDER_COUNT_EN.
- When defined, the block adds two outputs:
  - read_count[15:0]: counts accepted reads, including out-of-range reads;
  - write_count[15:0]: counts committed writes, excluding suppressed ones.
- Both counters reset to 0, saturate at 16'hFFFF, and clear on clear_status; an increment on the same edge as clear_status wins (counter becomes 1).
- When undefined, the ports and logic do not exist and behaviour is otherwise identical.

Test Plan:
- Reset then idle (CS=1, 10 clocks) -> data_oe=0, data_pins_out=16'h0000, contention=0, range_err=0.
- Write 16'hA55A to address 18'h00012 (CS=0, WE=0, one clock), then read the same address on the next clock with READ_LAT=1 -> data_oe=1 and data_pins_out=16'hA55A one clock after the read edge; data_oe=0 the following clock.
- READ_LAT=3, reads of addresses 0,1,2 on consecutive edges (preloaded 16'h1111, 16'h2222, 16'h3333) -> data_oe high for exactly 3 consecutive clocks starting 3 clocks after the first read edge, with data in order.
- CS=0, WE=0, OE=0 with data 16'hBEEF at address 5 -> mem[5] reads back 16'hBEEF, contention=1 and stays set; no data_oe pulse. clear_status pulse -> contention=0.
- ADDR_W=12, write 16'hFFFF to 18'h01000, then read 18'h00000 (preloaded 16'h0001) and read 18'h01000 -> address 0 still returns 16'h0001; out-of-range read returns 16'h0000 with data_oe=1; range_err=1.
- READ_LAT=2: read issued, reset pulsed low one clock later -> data_oe=0 immediately and stays 0 after reset releases, with no stale word emitted.
